imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The core only reads instruction memory, by `pc_out`.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into a writable instruction RAM at consecutive word addresses.
- Holds the core in reset while a load is in progress and releases it when the load completes.
- Sits beside the processor top, between a host/debug link and the instruction RAM write port.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_cksum.sv | 37 +++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared processor definitions used by the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. It enables the CHECK
// state and the checksum sub-module, and is honoured by the files that
// import this package.
package imem_loader_pkg;

  // Width of one instruction word.
  localparam int WORD_W = 32;

  // Bytes per instruction word. The program counter uses the same stride.
  localparam int WORD_BYTES = 4;

  // Loader states. CHECK is only reachable when the checksum is enabled.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

  // Returns the byte address of the next word after addr.
  function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
    return addr + WORD_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/imem_loader_cksum.sv
// Checksum accumulator for the instruction-memory loader.
// It is built only when IMEM_LOADER_CHECKSUM_EN is defined. The sum is the
// mod 2^32 total of every word written to RAM during the current load. The
// comparison against the trailing checksum word is combinational.
`ifdef IMEM_LOADER_CHECKSUM_EN
module imem_loader_cksum
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [WORD_W-1:0] add_data,
  input  logic [WORD_W-1:0] cmp_data,
  output logic              match
);

  logic [WORD_W-1:0] sum;

  // The running sum restarts with each load and adds each written word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

  // The candidate checksum word is compared against the current sum.
  always_comb begin
    match = (sum == cmp_data);
  end

endmodule
`endif

// File: rtl/imem_loader.sv
// imem_loader: the writer side of the instruction RAM.
// It accepts a valid/ready stream of 32-bit instruction words and writes them
// at consecutive word addresses starting at BASE_ADDR. It holds the core in
// reset while a load is in progress.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// checksum word after the last word. The checksum word is not written to RAM.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         ld_valid,
  input  logic [WORD_W-1:0]            ld_data,
  input  logic                         ld_last,
  output logic                         ld_ready,
  output logic                         imem_we,
  output logic [31:0]                  imem_addr,
  output logic [WORD_W-1:0]            imem_wdata,
  output logic                         core_reset_n,
  output logic                         load_done,
  output logic                         load_error,
  output logic [$clog2(DEPTH_WORDS):0] word_count
);

  localparam int            CW        = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [31:0]       addr_ptr;
  logic [31:0]       addr_ptr_nxt;
  logic [CW-1:0]     word_count_nxt;
  logic              imem_we_nxt;
  logic [31:0]       imem_addr_nxt;
  logic [WORD_W-1:0] imem_wdata_nxt;
  logic              ld_ready_nxt;
  logic              core_reset_n_nxt;
  logic              load_done_nxt;
  logic              load_error_nxt;
  logic              xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              cksum_clear;
  logic              cksum_add;
  logic              cksum_match;

  imem_loader_cksum u_cksum (
    .clock    (clock),
    .reset    (reset),
    .clear    (cksum_clear),
    .add_en   (cksum_add),
    .add_data (ld_data),
    .cmp_data (ld_data),
    .match    (cksum_match)
  );
`endif

  // ld_ready is a register, so a transfer depends on ld_valid only through
  // this AND. There is no combinational path from ld_valid to ld_ready.
  assign xfer = ld_valid & ld_ready;

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_nxt      = state;
    addr_ptr_nxt   = addr_ptr;
    word_count_nxt = word_count;
    imem_we_nxt    = 1'b0;
    imem_addr_nxt  = imem_addr;
    imem_wdata_nxt = imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cksum_clear    = 1'b0;
    cksum_add      = 1'b0;
`endif

    case (state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_nxt      = LOAD;
          addr_ptr_nxt   = BASE_ADDR;
          word_count_nxt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          cksum_clear    = 1'b1;
`endif
        end
      end

      LOAD: begin
        if (xfer) begin
          if (word_count == DEPTH_CNT) begin
            state_nxt = ERR;
          end else begin
            imem_we_nxt    = 1'b1;
            imem_addr_nxt  = addr_ptr;
            imem_wdata_nxt = ld_data;
            word_count_nxt = word_count + CW'(1);
            addr_ptr_nxt   = next_word_addr(addr_ptr);
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum_add      = 1'b1;
            if (ld_last) begin
              state_nxt = CHECK;
            end
`else
            if (ld_last) begin
              state_nxt = DONE;
            end
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          state_nxt = cksum_match ? DONE : ERR;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase

    ld_ready_nxt     = (state_nxt == LOAD) || (state_nxt == CHECK);
    core_reset_n_nxt = (state_nxt == IDLE) || (state_nxt == DONE);
    load_done_nxt    = (state_nxt == DONE);
    load_error_nxt   = (state_nxt == ERR);
  end

  // State register and registered outputs. Reset clears all of them, which
  // also holds the core in reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      addr_ptr     <= '0;
      word_count   <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      ld_ready     <= 1'b0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr_ptr     <= addr_ptr_nxt;
      word_count   <= word_count_nxt;
      imem_we      <= imem_we_nxt;
      imem_addr    <= imem_addr_nxt;
      imem_wdata   <= imem_wdata_nxt;
      ld_ready     <= ld_ready_nxt;
      core_reset_n <= core_reset_n_nxt;
      load_done    <= load_done_nxt;
      load_error   <= load_error_nxt;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances are used: A (64 words, base 0x0)
// and B (4 words, base 0x100). Expected RAM writes are queued when a word is
// handed over, and a monitor per instance pops and compares each imem_we
// pulse. Checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  reset      = 2'b00;
  logic [1:0]  load_start = 2'b00;
  logic [1:0]  ld_valid   = 2'b00;
  logic [1:0]  ld_last    = 2'b00;
  logic [31:0] ld_data [2];
  logic [1:0]  ld_ready;
  logic [1:0]  imem_we;
  logic [1:0]  core_reset_n;
  logic [1:0]  load_done;
  logic [1:0]  load_error;
  logic [31:0] imem_addr [2];
  logic [31:0] imem_wdata [2];
  logic [6:0]  word_count_a;
  logic [2:0]  word_count_b;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];

  imem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clock        (clock),
    .reset        (reset[0]),
    .load_start   (load_start[0]),
    .ld_valid     (ld_valid[0]),
    .ld_data      (ld_data[0]),
    .ld_last      (ld_last[0]),
    .ld_ready     (ld_ready[0]),
    .imem_we      (imem_we[0]),
    .imem_addr    (imem_addr[0]),
    .imem_wdata   (imem_wdata[0]),
    .core_reset_n (core_reset_n[0]),
    .load_done    (load_done[0]),
    .load_error   (load_error[0]),
    .word_count   (word_count_a)
  );

  imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clock        (clock),
    .reset        (reset[1]),
    .load_start   (load_start[1]),
    .ld_valid     (ld_valid[1]),
    .ld_data      (ld_data[1]),
    .ld_last      (ld_last[1]),
    .ld_ready     (ld_ready[1]),
    .imem_we      (imem_we[1]),
    .imem_addr    (imem_addr[1]),
    .imem_wdata   (imem_wdata[1]),
    .core_reset_n (core_reset_n[1]),
    .load_done    (load_done[1]),
    .load_error   (load_error[1]),
    .word_count   (word_count_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkState(input int d, input string tag, input logic rdy, input logic crn,
                            input logic done, input logic err, input logic [31:0] wc);
    logic [31:0] wc_act;
    wc_act = (d == 0) ? 32'(word_count_a) : 32'(word_count_b);
    checkOutput({tag, "_ld_ready"},     32'(ld_ready[d]),     32'(rdy));
    checkOutput({tag, "_core_reset_n"}, 32'(core_reset_n[d]), 32'(crn));
    checkOutput({tag, "_load_done"},    32'(load_done[d]),    32'(done));
    checkOutput({tag, "_load_error"},   32'(load_error[d]),   32'(err));
    checkOutput({tag, "_word_count"},   wc_act,               wc);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseStart(input int d);
    load_start[d] = 1'b1;
    @(negedge clock);
    load_start[d] = 1'b0;
  endtask

  // Offer one word and hold it until the loader accepts it. If the word
  // should reach RAM, queue the expected write.
  task automatic applyStimulus(input int d, input logic [31:0] data, input logic last,
                               input bit exp_write, input logic [31:0] exp_addr);
    int waited;
    waited = 0;
    ld_valid[d] = 1'b1;
    ld_data[d]  = data;
    ld_last[d]  = last;
    while (ld_ready[d] !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (ld_ready[d] !== 1'b1) begin
      total++;
      $display("[TB] FAIL handshake_timeout: ld_ready=%b on dut %0d, required 1", ld_ready[d], d);
    end else if (exp_write) begin
      if (d == 0) exp_q0.push_back({exp_addr, data});
      else        exp_q1.push_back({exp_addr, data});
    end
    @(negedge clock);
    ld_valid[d] = 1'b0;
    ld_last[d]  = 1'b0;
  endtask

  // In checksum builds the trailing checksum word follows the last word.
  task automatic finishLoad(input int d, input logic [31:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(d, sum, 1'b0, 1'b0, 32'h0);
`else
    if (d > 1) $display("[TB] unexpected dut index %0d (sum 0x%08h)", d, sum);
`endif
  endtask

  always @(negedge clock) begin : mon_a
    logic [63:0] e;
    if (imem_we[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        total++;
        $display("[TB] FAIL spurious_write_a: imem_we=1 addr 0x%08h data 0x%08h, required no write",
                 imem_addr[0], imem_wdata[0]);
      end else begin
        e = exp_q0.pop_front();
        checkOutput("write_addr_a", imem_addr[0], e[63:32]);
        checkOutput("write_data_a", imem_wdata[0], e[31:0]);
      end
    end
  end

  always @(negedge clock) begin : mon_b
    logic [63:0] e;
    if (imem_we[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        total++;
        $display("[TB] FAIL spurious_write_b: imem_we=1 addr 0x%08h data 0x%08h, required no write",
                 imem_addr[1], imem_wdata[1]);
      end else begin
        e = exp_q1.pop_front();
        checkOutput("write_addr_b", imem_addr[1], e[63:32]);
        checkOutput("write_data_b", imem_wdata[1], e[31:0]);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    ld_data[0] = '0;
    ld_data[1] = '0;

    // Reset state of A.
    waitCycles(1);
    checkState(0, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("reset_imem_we", 32'(imem_we[0]), 32'd0);
    checkOutput("reset_imem_addr", imem_addr[0], 32'd0);
    reset[0] = 1'b1;
    waitCycles(1);
    checkState(0, "idle", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Normal load of three words.
    pulseStart(0);
    checkState(0, "load", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, 32'h1, 1'b0, 1'b1, 32'h0);
    applyStimulus(0, 32'h2, 1'b0, 1'b1, 32'h4);
    applyStimulus(0, 32'h3, 1'b1, 1'b1, 32'h8);
    finishLoad(0, 32'h6);
    checkState(0, "normal_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'd3);

    // Words offered outside LOAD must not be written.
    ld_valid[0] = 1'b1;
    ld_data[0]  = 32'hDEAD_BEEF;
    waitCycles(3);
    ld_valid[0] = 1'b0;
    checkState(0, "valid_in_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'd3);

    // Gaps between words, with a load_start during LOAD that is ignored.
    pulseStart(0);
    checkState(0, "restart_done", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, 32'hA, 1'b0, 1'b1, 32'h0);
    pulseStart(0);
    applyStimulus(0, 32'hB, 1'b1, 1'b1, 32'h4);
    finishLoad(0, 32'h15);
    waitCycles(1);
    checkState(0, "gap_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'd2);

    // Reset asserted partway through a load.
    pulseStart(0);
    applyStimulus(0, 32'h11, 1'b0, 1'b1, 32'h0);
    applyStimulus(0, 32'h22, 1'b0, 1'b1, 32'h4);
    ld_valid[0] = 1'b1;
    ld_data[0]  = 32'h33;
    reset[0]    = 1'b0;
    waitCycles(1);
    checkState(0, "midreset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("midreset_imem_we", 32'(imem_we[0]), 32'd0);
    checkOutput("midreset_imem_addr", imem_addr[0], 32'd0);
    ld_valid[0] = 1'b0;
    waitCycles(1);
    reset[0] = 1'b1;
    waitCycles(1);
    checkState(0, "post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    pulseStart(0);
    applyStimulus(0, 32'h55, 1'b1, 1'b1, 32'h0);
    finishLoad(0, 32'h55);
    checkState(0, "post_reset_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum that matches.
    pulseStart(0);
    applyStimulus(0, 32'h10, 1'b0, 1'b1, 32'h0);
    applyStimulus(0, 32'h20, 1'b1, 1'b1, 32'h4);
    checkState(0, "check_phase", 1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
    applyStimulus(0, 32'h30, 1'b0, 1'b0, 32'h0);
    checkState(0, "cksum_ok", 1'b0, 1'b1, 1'b1, 1'b0, 32'd2);

    // Checksum that does not match.
    pulseStart(0);
    applyStimulus(0, 32'h10, 1'b0, 1'b1, 32'h0);
    applyStimulus(0, 32'h20, 1'b1, 1'b1, 32'h4);
    applyStimulus(0, 32'h31, 1'b0, 1'b0, 32'h0);
    waitCycles(1);
    checkState(0, "cksum_bad", 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
`endif

    // Overflow on B: four words fill the RAM and the fifth is rejected.
    reset[1] = 1'b1;
    waitCycles(1);
    pulseStart(1);
    applyStimulus(1, 32'hC0, 1'b0, 1'b1, 32'h100);
    applyStimulus(1, 32'hC1, 1'b0, 1'b1, 32'h104);
    applyStimulus(1, 32'hC2, 1'b0, 1'b1, 32'h108);
    applyStimulus(1, 32'hC3, 1'b0, 1'b1, 32'h10C);
    checkState(1, "full", 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
    applyStimulus(1, 32'hC4, 1'b0, 1'b0, 32'h0);
    waitCycles(1);
    checkState(1, "overflow", 1'b0, 1'b0, 1'b0, 1'b1, 32'd4);

    // Restart from ERR, then fill exactly to capacity with ld_last.
    pulseStart(1);
    checkState(1, "restart_err", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 32'h11, 1'b0, 1'b1, 32'h100);
    applyStimulus(1, 32'h22, 1'b0, 1'b1, 32'h104);
    applyStimulus(1, 32'h33, 1'b0, 1'b1, 32'h108);
    applyStimulus(1, 32'h44, 1'b1, 1'b1, 32'h10C);
    finishLoad(1, 32'hAA);
    checkState(1, "exact_fill", 1'b0, 1'b1, 1'b1, 1'b0, 32'd4);

    waitCycles(3);
    checkOutput("pending_writes_a", 32'(exp_q0.size()), 32'd0);
    checkOutput("pending_writes_b", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
